// File: rtl/fft_64_frame_packer_pkg.sv
// Shared constants and read-FSM encoding for the 64-point FFT frame packer.
package fft_64_frame_packer_pkg;
  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 64;
  localparam int LANES     = 4;
  localparam int BEATS     = FRAME_LEN / LANES;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int BEAT_W    = $clog2(BEATS);
  localparam int LANE_W    = $clog2(LANES);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } rd_state_t;
endpackage

// File: rtl/fft_64_lane_ram.sv
// Simple dual-port RAM holding one lane of one frame bank; registered read.
module fft_64_lane_ram #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/fft_64_frame_packer.sv
// Packs serial complex samples into 16 four-lane beats per 64-sample frame,
// ping-pong buffered across two banks so input and output overlap.
module fft_64_frame_packer #(
  parameter int DATA_W = fft_64_frame_packer_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic [DATA_W-1:0] s_x_in,
  input  logic [DATA_W-1:0] s_y_in,
  input  logic              s_valid_in,
  output logic              s_ready_out,
  input  logic              out_en_in,
  output logic [DATA_W-1:0] x_a_out,
  output logic [DATA_W-1:0] y_a_out,
  output logic [DATA_W-1:0] x_b_out,
  output logic [DATA_W-1:0] y_b_out,
  output logic [DATA_W-1:0] x_c_out,
  output logic [DATA_W-1:0] y_c_out,
  output logic [DATA_W-1:0] x_d_out,
  output logic [DATA_W-1:0] y_d_out,
  output logic              ctrl_out
);
  import fft_64_frame_packer_pkg::*;
  localparam int SW = 2 * DATA_W;

  logic [1:0]                    full, set_full, clr_full;
  logic                          wr_bank, rd_bank;
  logic [IDX_W-1:0]              wr_idx;
  logic                          accept;
  rd_state_t                     state, state_nxt;
  logic [BEAT_W-1:0]             k, k_nxt, raddr;
  logic                          issue, first, rd_done;
  logic                          rd_vld, first_q, bank_q, done_q;
  logic [1:0][LANES-1:0][SW-1:0] rdata;
  logic [LANES-1:0][SW-1:0]      lane_q;

  assign s_ready_out = ~full[wr_bank] & ~rst_in;
  assign accept      = s_valid_in & s_ready_out;

  // The bank is released when its last beat lands on the outputs, so a
  // streamed bank can never be overwritten.
  always_comb begin
    set_full = '0;
    clr_full = '0;
    if (accept && (&wr_idx)) set_full[wr_bank] = 1'b1;
    if (done_q)              clr_full[bank_q]  = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    raddr     = k;
    issue     = 1'b0;
    first     = 1'b0;
    rd_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (full[rd_bank] && out_en_in) begin
          issue     = 1'b1;
          first     = 1'b1;
          raddr     = '0;
          k_nxt     = BEAT_W'(1);
          state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        issue = 1'b1;
        first = (k == '0);
        k_nxt = k + 1'b1;
        if (k == BEAT_W'(BEATS - 1)) begin
          rd_done = 1'b1;
          if (!(full[~rd_bank] && out_en_in)) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      k       <= '0;
      wr_idx  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= '0;
      rd_vld  <= 1'b0;
      first_q <= 1'b0;
      bank_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      k    <= k_nxt;
      full <= (full & ~clr_full) | set_full;
      if (accept) begin
        wr_idx <= wr_idx + 1'b1;
        if (&wr_idx) wr_bank <= ~wr_bank;
      end
      if (rd_done) rd_bank <= ~rd_bank;
      rd_vld  <= issue;
      first_q <= first;
      bank_q  <= rd_bank;
      done_q  <= rd_done;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in || !rd_vld) begin
      lane_q   <= '0;
      ctrl_out <= 1'b0;
    end else begin
      lane_q   <= rdata[bank_q];
      ctrl_out <= first_q;
    end
  end

  // Sample n lands in lane n[5:4] at address n[3:0]; a beat reads one address across all lanes.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      fft_64_lane_ram #(.WIDTH(SW), .AW(BEAT_W)) u_ram (
        .clk   (clk),
        .we    (accept && (wr_bank == 1'(b)) && (wr_idx[IDX_W-1 -: LANE_W] == LANE_W'(l))),
        .waddr (wr_idx[BEAT_W-1:0]),
        .wdata ({s_x_in, s_y_in}),
        .raddr (raddr),
        .rdata (rdata[b][l])
      );
    end
  end

  assign x_a_out = lane_q[0][SW-1 -: DATA_W];
  assign y_a_out = lane_q[0][DATA_W-1:0];
  assign x_b_out = lane_q[1][SW-1 -: DATA_W];
  assign y_b_out = lane_q[1][DATA_W-1:0];
  assign x_c_out = lane_q[2][SW-1 -: DATA_W];
  assign y_c_out = lane_q[2][DATA_W-1:0];
  assign x_d_out = lane_q[3][SW-1 -: DATA_W];
  assign y_d_out = lane_q[3][DATA_W-1:0];
endmodule

// File: tb/tb_fft_64_frame_packer.sv
// Directed + randomized bench for fft_64_frame_packer against a frame-level
// reference model (completed frames queue, timed beat emission).
module tb_fft_64_frame_packer;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_in = 1'b1;
  logic          s_valid_in = 1'b0;
  logic          out_en_in = 1'b0;
  logic [DW-1:0] s_x_in = '0, s_y_in = '0;
  logic          s_ready_out, ctrl_out;
  logic [DW-1:0] x_a_out, y_a_out, x_b_out, y_b_out;
  logic [DW-1:0] x_c_out, y_c_out, x_d_out, y_d_out;

  always #5 clk = ~clk;

  fft_64_frame_packer #(.DATA_W(DW)) dut (
    .clk(clk), .rst_in(rst_in), .s_x_in(s_x_in), .s_y_in(s_y_in),
    .s_valid_in(s_valid_in), .s_ready_out(s_ready_out), .out_en_in(out_en_in),
    .x_a_out(x_a_out), .y_a_out(y_a_out), .x_b_out(x_b_out), .y_b_out(y_b_out),
    .x_c_out(x_c_out), .y_c_out(y_c_out), .x_d_out(x_d_out), .y_d_out(y_d_out),
    .ctrl_out(ctrl_out)
  );

  // Reference model: every completed frame is appended to all_x/all_y and
  // stamped with its completion edge; frames are streamed in order.
  logic [DW-1:0] all_x [$], all_y [$];
  int            fdone [$];
  logic [DW-1:0] px [64], py [64];
  int n_in = 0, n_done = 0, n_rel = 0, next_f = 0;
  int iss = -1, iss_f = 0, disp = -1, disp_f = 0;
  int edge_no = 0;
  int n_cmp = 0, n_bad = 0;
  int last_ctrl = -1;
  bit chk_period = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s @edge %0d: got %0h, expected %0h", tag, edge_no, obs, exp);
    end
  endtask

  task automatic cycle(input bit rst, input bit vld, input logic [DW-1:0] x,
                       input logic [DW-1:0] y, input bit oe);
    bit acc;
    logic [DW-1:0] ox [4], oy [4];
    logic [DW-1:0] ex, ey;
    rst_in = rst; s_valid_in = vld; s_x_in = x; s_y_in = y; out_en_in = oe;
    acc = vld && !rst && ((n_done - n_rel) < 2);
    @(posedge clk);
    edge_no++;
    if (rst) begin
      iss = -1; disp = -1; n_in = 0; next_f = n_done; n_rel = n_done;
    end else begin
      // a beat is shown one edge after it is scheduled; a frame may be
      // scheduled once it completed on an earlier edge and the previous
      // frame has scheduled its last beat
      disp = iss; disp_f = iss_f;
      if (disp == 15) n_rel++;
      if (iss >= 0 && iss < 15) iss++;
      else if (oe && next_f < n_done && fdone[next_f] <= edge_no - 1) begin
        iss = 0; iss_f = next_f; next_f++;
      end else iss = -1;
      if (acc) begin
        px[n_in] = x; py[n_in] = y; n_in++;
        if (n_in == 64) begin
          for (int i = 0; i < 64; i++) begin
            all_x.push_back(px[i]); all_y.push_back(py[i]);
          end
          fdone.push_back(edge_no); n_done++; n_in = 0;
        end
      end
    end
    #1;
    chk("s_ready", 32'(s_ready_out), 32'(!rst && ((n_done - n_rel) < 2)));
    chk("ctrl", 32'(ctrl_out), 32'(disp == 0));
    ox[0] = x_a_out; ox[1] = x_b_out; ox[2] = x_c_out; ox[3] = x_d_out;
    oy[0] = y_a_out; oy[1] = y_b_out; oy[2] = y_c_out; oy[3] = y_d_out;
    for (int l = 0; l < 4; l++) begin
      ex = (disp >= 0) ? all_x[disp_f*64 + disp + 16*l] : '0;
      ey = (disp >= 0) ? all_y[disp_f*64 + disp + 16*l] : '0;
      chk($sformatf("x_lane%0d", l), 32'(ox[l]), 32'(ex));
      chk($sformatf("y_lane%0d", l), 32'(oy[l]), 32'(ey));
    end
    if (chk_period && ctrl_out === 1'b1) begin
      if (last_ctrl >= 0) chk("ctrl_period", 32'(edge_no - last_ctrl), 32'd64);
      last_ctrl = edge_no;
    end
  endtask

  task automatic idle(input int n, input bit oe);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, oe);
  endtask

  initial begin
    // reset state
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 16'h1234, 16'h5678, 1'b1);

    // impulse
    for (int n = 0; n < 64; n++) cycle(1'b0, 1'b1, (n == 0) ? 16'd1 : 16'd0, '0, 1'b1);
    idle(20, 1'b1);

    // ramp (n, -n)
    for (int n = 0; n < 64; n++) cycle(1'b0, 1'b1, DW'(n), DW'(-n), 1'b1);
    idle(20, 1'b1);

    // three frames of continuous valid: ready stays high, ctrl every 64 edges
    chk_period = 1'b1; last_ctrl = -1;
    for (int i = 0; i < 192; i++) cycle(1'b0, 1'b1, DW'($urandom), DW'($urandom), 1'b1);
    idle(20, 1'b1);
    chk_period = 1'b0;

    // downstream blocked: both banks fill, then two back-to-back frames
    for (int i = 0; i < 130; i++) cycle(1'b0, 1'b1, DW'($urandom), DW'($urandom), 1'b0);
    idle(5, 1'b0);
    idle(40, 1'b1);

    // reset while beat 7 is on the outputs, then a fresh frame
    for (int i = 0; i < 64; i++) cycle(1'b0, 1'b1, DW'($urandom), DW'($urandom), 1'b1);
    for (int g = 0; g < 20 && disp != 7; g++) idle(1, 1'b1);
    chk("at_beat7", 32'(disp), 32'd7);
    cycle(1'b1, 1'b0, '0, '0, 1'b1);
    cycle(1'b1, 1'b0, '0, '0, 1'b1);
    idle(25, 1'b1);
    for (int n = 0; n < 64; n++) cycle(1'b0, 1'b1, DW'(n + 100), DW'($urandom), 1'b1);
    idle(20, 1'b1);

    // reset during a partial write
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, DW'($urandom), DW'($urandom), 1'b1);
    cycle(1'b1, 1'b1, '0, '0, 1'b1);
    for (int n = 0; n < 64; n++) cycle(1'b0, 1'b1, DW'($urandom), DW'($urandom), 1'b1);
    idle(20, 1'b1);

    // random valid gaps
    for (int i = 0; i < 600; i++)
      cycle(1'b0, $urandom_range(0, 3) != 0, DW'($urandom), DW'($urandom), 1'b1);
    idle(30, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
